// File: rtl/game_round_sequencer_if.sv
// Datapath command/status bundle between game_round_sequencer (master)
// and the memory-game datapath (slave).
//   R1       clear all datapath registers and counters
//   R2       clear user-entry registers
//   E1       load setup register (switches)
//   E2       enable FPGA sequence display counter
//   E3       enable user input capture
//   E4       load result register
//   SEL      display mux: 0 = game, 1 = result
//   end_FPGA datapath finished displaying the sequence
//   end_User datapath captured the full user sequence
//   match    user sequence equals FPGA sequence
interface game_round_sequencer_if;
  logic R1, R2, E1, E2, E3, E4, SEL;
  logic end_FPGA, end_User, match;

  modport master (
    output R1, R2, E1, E2, E3, E4, SEL,
    input  end_FPGA, end_User, match
  );

  modport slave (
    input  R1, R2, E1, E2, E3, E4, SEL,
    output end_FPGA, end_User, match
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Control FSM for the memory game: setup, FPGA sequence display, user
// entry, compare, round advance, result. Owns the enter-key synchroniser
// and edge detector, the round counter and the user-entry timeout.
//
// Ports:
//   CLOCK     system clock
//   reset     asynchronous active-low reset
//   enter     raw active-low key, asynchronous to CLOCK
//   dp        datapath strobes (out) and status flags (in)
//   round     current round, 1-based, 0 before play
//   time_left ticks remaining while in PLAY, else 0
//   win/lose  game result, held in RESULT
//
// Optional feature macro ROUND_SPEEDUP_EN: when defined, the timeout
// shrinks by one tick per round past the first, floored at 2 ticks.
module game_round_sequencer #(
  parameter int TICK_DIV     = 50000000,
  parameter int USER_TIMEOUT = 10,
  parameter int MAX_ROUNDS   = 8,
  parameter int ROUND_W      = 4
) (
  input  logic                        CLOCK,
  input  logic                        reset,
  input  logic                        enter,
  game_round_sequencer_if.master      dp,
  output logic [ROUND_W-1:0]          round,
  output logic [ROUND_W-1:0]          time_left,
  output logic                        win,
  output logic                        lose
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SHOW   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [ROUND_W-1:0] sec_q, sec_d;
  logic               win_q, win_d, lose_q, lose_d;
  logic               res_seen_q;
  logic               enter_s1_q, enter_s2_q, enter_s3_q;
  logic               enter_p;
  logic [ROUND_W-1:0] limit;

  // Two-flop synchroniser plus one history flop; the key is active-low,
  // so a press is a 1 -> 0 edge on the synchronised level.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      enter_s1_q <= 1'b1;
      enter_s2_q <= 1'b1;
      enter_s3_q <= 1'b1;
    end else begin
      enter_s1_q <= enter;
      enter_s2_q <= enter_s1_q;
      enter_s3_q <= enter_s2_q;
    end
  end

  assign enter_p = enter_s3_q & ~enter_s2_q;

`ifdef ROUND_SPEEDUP_EN
  int lim_i;
  always_comb begin
    lim_i = USER_TIMEOUT;
    if (round_q > 1) lim_i = USER_TIMEOUT - (int'(round_q) - 1);
    if (lim_i < 2) lim_i = 2;
    limit = ROUND_W'(lim_i);
  end
`else
  assign limit = ROUND_W'(USER_TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    tick_d  = '0;
    sec_d   = '0;
    win_d   = win_q;
    lose_d  = lose_q;
    case (state_q)
      S_INIT:  state_d = S_SETUP;
      S_SETUP: if (enter_p) begin
        state_d = S_SHOW;
        round_d = ROUND_W'(1);
      end
      S_SHOW:  if (dp.end_FPGA) state_d = S_PLAY;
      S_PLAY: begin
        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d = '0;
          sec_d  = (sec_q < limit) ? sec_q + 1'b1 : sec_q;
        end else begin
          tick_d = tick_q + 1'b1;
          sec_d  = sec_q;
        end
        // A finished entry in the timeout cycle still gets compared.
        if (dp.end_User) begin
          state_d = S_CHECK;
        end else if (sec_q == limit) begin
          state_d = S_RESULT;
          lose_d  = 1'b1;
        end
      end
      S_CHECK: begin
        if (!dp.match) begin
          state_d = S_RESULT;
          lose_d  = 1'b1;
        end else if (round_q == ROUND_W'(MAX_ROUNDS)) begin
          state_d = S_RESULT;
          win_d   = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = S_SHOW;
        round_d = round_q + 1'b1;
      end
      S_RESULT: if (enter_p) state_d = S_INIT;
      default:  state_d = S_INIT;
    endcase
    // Timer only runs while in PLAY; clear it on the way out.
    if (state_d != S_PLAY) begin
      tick_d = '0;
      sec_d  = '0;
    end
    if (state_d == S_INIT) begin
      round_d = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      round_q    <= '0;
      tick_q     <= '0;
      sec_q      <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      res_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      tick_q     <= tick_d;
      sec_q      <= sec_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      res_seen_q <= (state_q == S_RESULT);
    end
  end

  // Moore strobes; INIT is forced during reset so R1/R2 follow it.
  assign dp.R1  = (state_q == S_INIT);
  assign dp.R2  = (state_q == S_INIT) | (state_q == S_NEXT);
  assign dp.E1  = (state_q == S_SETUP);
  assign dp.E2  = (state_q == S_SHOW);
  assign dp.E3  = (state_q == S_PLAY);
  assign dp.E4  = (state_q == S_RESULT) & ~res_seen_q;
  assign dp.SEL = (state_q == S_RESULT);

  assign round     = round_q;
  assign time_left = (state_q == S_PLAY) ? limit - sec_q : '0;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
module tb_game_round_sequencer;
  localparam int TD = 4;
  localparam int UT = 3;
  localparam int MR = 2;
  localparam int RW = 4;

  logic          CLOCK = 1'b0;
  logic          reset = 1'b0;
  logic          enter = 1'b1;
  logic [RW-1:0] round, time_left;
  logic          win, lose;
  int            total = 0;
  int            bad   = 0;

  game_round_sequencer_if dp_if();

  game_round_sequencer #(
    .TICK_DIV(TD), .USER_TIMEOUT(UT), .MAX_ROUNDS(MR), .ROUND_W(RW)
  ) dut (
    .CLOCK(CLOCK), .reset(reset), .enter(enter), .dp(dp_if),
    .round(round), .time_left(time_left), .win(win), .lose(lose)
  );

  always #5 CLOCK = ~CLOCK;

  // Phase as visible from the strobe table: 0 INIT, 1 SETUP, 2 SHOW,
  // 3 PLAY, 4 CHECK (no strobe), 5 NEXT, 6 RESULT.
  function automatic int phase();
    if (dp_if.R1)  return 0;
    if (dp_if.E1)  return 1;
    if (dp_if.E2)  return 2;
    if (dp_if.E3)  return 3;
    if (dp_if.SEL) return 6;
    if (dp_if.R2)  return 5;
    return 4;
  endfunction

  // Timeout length in ticks for a given round.
  function automatic int limit_for(input int r);
`ifdef ROUND_SPEEDUP_EN
    int l;
    l = UT - (r - 1);
    return (l < 2) ? 2 : l;
`else
    return UT;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic wait_phase(input int p, input int budget, output int got);
    int n = 0;
    while (phase() != p && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    got = phase();
  endtask

  task automatic go_setup();
    int got;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    wait_phase(1, 4, got);
    total++;
    if (got !== 1) begin bad++; $display("FAIL go_setup: phase=%0d want=1", got); end
  endtask

  task automatic start_game(input int len);
    int got;
    enter = 1'b0;
    cyc(len);
    enter = 1'b1;
    wait_phase(2, 8, got);
    total++;
    if (got !== 2 || round !== 4'd1) begin
      bad++; $display("FAIL start_game: phase=%0d round=%0d want 2/1", got, round);
    end
  endtask

  // From SHOW: wait fd cycles, pulse end_FPGA, land in PLAY.
  task automatic start_round(input int fd);
    cyc(fd);
    dp_if.end_FPGA = 1'b1;
    @(negedge CLOCK);
    dp_if.end_FPGA = 1'b0;
    total++;
    if (phase() !== 3) begin bad++; $display("FAIL start_round: phase=%0d want=3", phase()); end
  endtask

  // From PLAY: wait ud cycles, report completion with match bit m, land in CHECK.
  task automatic finish_round(input int ud, input logic m);
    cyc(ud);
    dp_if.match    = m;
    dp_if.end_User = 1'b1;
    @(negedge CLOCK);
    dp_if.end_User = 1'b0;
    total++;
    if (phase() !== 4) begin bad++; $display("FAIL finish_round: phase=%0d want=4", phase()); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    total++;
    if ({dp_if.R1, dp_if.R2, dp_if.E1, dp_if.E2, dp_if.E3, dp_if.E4, dp_if.SEL} !== 7'b1100000) begin
      bad++; $display("FAIL reset_strobes: got=%b want=1100000",
        {dp_if.R1, dp_if.R2, dp_if.E1, dp_if.E2, dp_if.E3, dp_if.E4, dp_if.SEL});
    end
    total++;
    if (round !== 0 || time_left !== 0 || win !== 0 || lose !== 0) begin
      bad++; $display("FAIL reset_state: round=%0d tl=%0d win=%b lose=%b", round, time_left, win, lose);
    end
    reset = 1'b1;
    #1;
    total++;
    if (dp_if.R1 !== 1'b1) begin bad++; $display("FAIL init_hold: R1=%b want=1", dp_if.R1); end
    @(negedge CLOCK);
    total++;
    if (dp_if.E1 !== 1'b1 || dp_if.R1 !== 1'b0) begin
      bad++; $display("FAIL init_to_setup: E1=%b R1=%b want 1/0", dp_if.E1, dp_if.R1);
    end
  endtask

  task automatic test_held_enter();
    int entries = 0;
    int prev;
    prev = phase();
    enter = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      if (prev != 2 && phase() == 2) entries++;
      prev = phase();
    end
    enter = 1'b1;
    total++;
    if (entries !== 1 || round !== 4'd1) begin
      bad++; $display("FAIL held_enter: entries=%0d round=%0d want 1/1", entries, round);
    end
    // In SHOW: an enter press and a stray end_User must not move the FSM.
    enter = 1'b0;
    cyc(4);
    enter = 1'b1;
    dp_if.end_User = 1'b1;
    @(negedge CLOCK);
    dp_if.end_User = 1'b0;
    cyc(3);
    total++;
    if (phase() !== 2) begin bad++; $display("FAIL show_ignore: phase=%0d want=2", phase()); end
  endtask

  task automatic test_win();
    go_setup();
    start_game(2);
    start_round(2);
    finish_round(3, 1'b1);
    @(negedge CLOCK);
    total++;
    if (phase() !== 5 || dp_if.R2 !== 1'b1) begin
      bad++; $display("FAIL win_next: phase=%0d R2=%b want 5/1", phase(), dp_if.R2);
    end
    @(negedge CLOCK);
    total++;
    if (phase() !== 2 || round !== 4'd2) begin
      bad++; $display("FAIL win_round2: phase=%0d round=%0d want 2/2", phase(), round);
    end
    start_round(1);
    finish_round(2, 1'b1);
    @(negedge CLOCK);
    total++;
    if (phase() !== 6 || win !== 1'b1 || lose !== 1'b0 || dp_if.E4 !== 1'b1) begin
      bad++; $display("FAIL win_result: phase=%0d win=%b lose=%b E4=%b", phase(), win, lose, dp_if.E4);
    end
    @(negedge CLOCK);
    total++;
    if (dp_if.E4 !== 1'b0 || win !== 1'b1 || dp_if.SEL !== 1'b1) begin
      bad++; $display("FAIL win_e4_once: E4=%b win=%b SEL=%b want 0/1/1", dp_if.E4, win, dp_if.SEL);
    end
  endtask

  task automatic test_mismatch();
    int got;
    go_setup();
    start_game(1);
    start_round(0);
    finish_round(1, 1'b0);
    @(negedge CLOCK);
    total++;
    if (phase() !== 6 || lose !== 1'b1 || win !== 1'b0 || round !== 4'd1) begin
      bad++; $display("FAIL mismatch: phase=%0d lose=%b win=%b round=%0d", phase(), lose, win, round);
    end
    enter = 1'b0;
    cyc(2);
    enter = 1'b1;
    wait_phase(0, 4, got);
    total++;
    if (got !== 0 || lose !== 1'b0) begin
      bad++; $display("FAIL result_exit: phase=%0d lose=%b want 0/0", got, lose);
    end
    @(negedge CLOCK);
    total++;
    if (phase() !== 1) begin bad++; $display("FAIL result_setup: phase=%0d want=1", phase()); end
  endtask

  // Starting at the first PLAY cycle of round r, watch the countdown.
  // An enter press in the middle must be ignored.
  task automatic run_timeout(input int r, input bit bump);
    int l;
    l = limit_for(r);
    for (int n = 0; n <= l * TD; n++) begin
      if (n == 2) enter = 1'b0;
      if (n == 5) enter = 1'b1;
      total++;
      if (phase() !== 3 || time_left !== RW'(l - n / TD)) begin
        bad++; $display("FAIL countdown r%0d n%0d: phase=%0d tl=%0d want 3/%0d", r, n, phase(), time_left, l - n / TD);
      end
      if (n < l * TD) @(negedge CLOCK);
    end
    if (bump) begin
      dp_if.match    = 1'b1;
      dp_if.end_User = 1'b1;
      @(negedge CLOCK);
      dp_if.end_User = 1'b0;
      total++;
      if (phase() !== 4) begin bad++; $display("FAIL timeout_tie: phase=%0d want=4", phase()); end
    end else begin
      @(negedge CLOCK);
      total++;
      if (phase() !== 6 || lose !== 1'b1 || win !== 1'b0 || round !== RW'(r)) begin
        bad++; $display("FAIL timeout_lose r%0d: phase=%0d lose=%b win=%b round=%0d", r, phase(), lose, win, round);
      end
    end
  endtask

  task automatic test_timeout();
    go_setup();
    start_game(3);
    start_round(1);
    run_timeout(1, 1'b0);
    go_setup();
    start_game(1);
    start_round(2);
    run_timeout(1, 1'b1);
    @(negedge CLOCK);
    total++;
    if (phase() !== 5) begin bad++; $display("FAIL tie_next: phase=%0d want=5", phase()); end
  endtask

  task automatic test_speedup();
    go_setup();
    start_game(2);
    start_round(1);
    finish_round(1, 1'b1);
    cyc(2);
    start_round(1);
    run_timeout(2, 1'b0);
  endtask

  task automatic test_mid_reset();
    go_setup();
    start_game(1);
    start_round(1);
    cyc(5);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dp_if.R1 !== 1'b1 || round !== 0 || win !== 0 || lose !== 0 || time_left !== 0) begin
      bad++; $display("FAIL mid_reset: R1=%b round=%0d win=%b lose=%b tl=%0d", dp_if.R1, round, win, lose, time_left);
    end
    @(negedge CLOCK);
    reset = 1'b1;
    @(negedge CLOCK);
    total++;
    if (phase() !== 1) begin bad++; $display("FAIL mid_reset_recover: phase=%0d want=1", phase()); end
  endtask

  // Random games: a game is won by MR consecutive matches, lost on the
  // first mismatch; the round shown is the round being played.
  task automatic test_random_games();
    for (int g = 0; g < 8; g++) begin
      int  r;
      bit  done;
      go_setup();
      start_game($urandom_range(1, 6));
      r = 1;
      done = 0;
      while (!done) begin
        logic m;
        m = ($urandom_range(0, 3) != 0);
        total++;
        if (round !== RW'(r)) begin bad++; $display("FAIL rand g%0d round=%0d want=%0d", g, round, r); end
        start_round($urandom_range(0, 5));
        finish_round($urandom_range(0, 6), m);
        @(negedge CLOCK);
        total++;
        if (!m) begin
          done = 1;
          if (phase() !== 6 || lose !== 1 || win !== 0) begin
            bad++; $display("FAIL rand g%0d lose: phase=%0d lose=%b win=%b", g, phase(), lose, win);
          end
        end else if (r == MR) begin
          done = 1;
          if (phase() !== 6 || win !== 1 || lose !== 0) begin
            bad++; $display("FAIL rand g%0d win: phase=%0d lose=%b win=%b", g, phase(), lose, win);
          end
        end else begin
          if (phase() !== 5) begin bad++; $display("FAIL rand g%0d next: phase=%0d", g, phase()); end
          @(negedge CLOCK);
          r++;
        end
      end
    end
  endtask

  initial begin
    dp_if.end_FPGA = 1'b0;
    dp_if.end_User = 1'b0;
    dp_if.match    = 1'b0;
    @(negedge CLOCK);
    test_reset();
    test_held_enter();
    test_win();
    test_mismatch();
    test_timeout();
    test_speedup();
    test_mid_reset();
    test_random_games();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end
endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Control FSM that sequences the memory-game datapath: setup, FPGA sequence display, user entry, compare, round advance, result.
- Drives the datapath command strobes R1, R2, E1-E4 and SEL, and consumes its status flags end_FPGA, end_User and match.
- Owns the enter-key synchroniser and edge detector, the round counter and the user-entry timeout. The datapath needs no timer of its own.
- Instantiated in topo beside the datapath, replacing the bare Controle stub.

Parameters:
- TICK_DIV, 50000000, CLOCK cycles per timeout tick (1 s at 50 MHz). Benches use 4.
- USER_TIMEOUT, 10, ticks allowed in PLAY before the user loses (range 2..15).
- MAX_ROUNDS, 8, rounds to win (range 1..15).
- ROUND_W, 4, width of the round counter and time_left.

Ports:
- CLOCK, in, 1, system clock (CLOCK_50).
- reset, in, 1, asynchronous active-low reset.
- enter, in, 1, raw KEY, active-low, asynchronous to CLOCK.
- end_FPGA, in, 1, datapath finished displaying the sequence.
- end_User, in, 1, datapath captured the full user sequence.
- match, in, 1, user sequence equals FPGA sequence; sampled only in CHECK.
- R1, out, 1, clear all datapath registers and counters.
- R2, out, 1, clear user-entry registers.
- E1, out, 1, load setup register (switches).
- E2, out, 1, enable FPGA sequence display counter.
- E3, out, 1, enable user input capture.
- E4, out, 1, load result register.
- SEL, out, 1, display mux: 0 = game, 1 = result.
- round, out, ROUND_W, current round (1-based; 0 before play).
- time_left, out, ROUND_W, USER_TIMEOUT minus elapsed ticks while in PLAY, else 0.
- win, out, 1, game won; held in RESULT.
- lose, out, 1, game lost; held in RESULT.

Behaviour:
- Enter key:
  - 2-flop synchroniser, then falling-edge detect.
  - Produces a 1-cycle enter_p per press; a held key gives exactly one pulse.
  - enter_p is ignored in every state except SETUP and RESULT.
- State register, 3 bits: INIT=0, SETUP=1, SHOW=2, PLAY=3, CHECK=4, NEXT=5, RESULT=6. Codes 7 and above go to INIT next cycle.
- Reset (asserted at any time, including mid-game): state=INIT, round=0, tick and sec counters=0, win=lose=0, synchroniser flops=1 (key released).
- Strobes are Moore-decoded from state (zero latency):
  - INIT: R1=1, R2=1. This holds while reset is asserted.
  - SETUP: E1=1.
  - SHOW: E2=1.
  - PLAY: E3=1.
  - NEXT: R2=1.
  - RESULT: SEL=1.
  - E4=1 only in the first cycle of RESULT.
  - All other strobes are 0.
- Transitions:
  - INIT -> SETUP after 1 cycle.
  - SETUP -> SHOW on enter_p; round<=1.
  - SHOW -> PLAY on end_FPGA; tick and sec counters cleared.
  - PLAY -> CHECK on end_User.
  - PLAY -> RESULT with lose<=1 when sec == USER_TIMEOUT.
  - PLAY: if end_User and timeout occur in the same cycle, end_User has priority.
  - CHECK, 1 cycle:
    - if !match: -> RESULT, lose<=1.
    - else if round == MAX_ROUNDS: -> RESULT, win<=1.
    - else: -> NEXT.
  - NEXT -> SHOW after 1 cycle; round<=round+1.
  - RESULT -> INIT on enter_p; win and lose cleared on entering INIT.
- Timeout counters, PLAY only:
  - tick counter runs 0..TICK_DIV-1 and wraps.
  - sec increments on each wrap and saturates at USER_TIMEOUT.
  - Both counters are held at 0 outside PLAY.
- Status inputs are ignored outside their states, e.g. end_FPGA in PLAY and end_User in SHOW.
- win and lose are never 1 together.

Optional Feature:
- Macro: ROUND_SPEEDUP_EN.
- Defined: the effective timeout is USER_TIMEOUT-(round-1), floored at 2 ticks. The same limit is used for both time_left and the lose condition.
- Undefined: the timeout is a fixed USER_TIMEOUT in every round.

Test Plan:
All scenarios use TICK_DIV=4, USER_TIMEOUT=3, MAX_ROUNDS=2 unless noted.
1. Reset released -> R1=R2=1 for 1 cycle, then SETUP with E1=1. Hold enter low for 20 cycles -> exactly one SETUP->SHOW transition, round=1.
2. Win path: end_FPGA pulse, end_User with match=1 (round 1) -> NEXT (R2=1), round=2. Repeat with match=1 -> RESULT, win=1, SEL=1, E4=1 for exactly 1 cycle.
3. Mismatch: round 1, end_User with match=0 -> CHECK -> RESULT, lose=1, win=0, round stays 1. Press enter -> INIT, then SETUP.
4. Timeout: enter PLAY and never assert end_User -> time_left counts 3,2,1,0, one step per 4 cycles. RESULT with lose=1 occurs 12 cycles after PLAY entry. end_User pulsed in that exact cycle -> CHECK instead.
5. Reset asserted mid-PLAY -> all state cleared within the same cycle (asynchronous): R1=1, round=0, win=lose=0. Enter pulses during SHOW or PLAY -> no state change.
6. With ROUND_SPEEDUP_EN, USER_TIMEOUT=3, round 2 -> lose after 2 ticks (8 cycles). Without the macro -> lose after 12 cycles.
